encout_ctrl: RTL and testbench

Sequencing controller for the encoder-output channel. It takes the decoded register strobes and field values from the APB register block (CTL, STR, POSMAX, OUTCNT, POSCNT) and generates a burst of quadrature A/B edges at a programmed rate. It maintains the wrapping position counter and reports busy/done status back to the register block for readback. It sits between the register block and the encoder output pins.

---
 rtl/encout_ctrl.sv | 159 +++++++++++++++
 tb/tb_encout_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/encout_ctrl.sv
// Encoder-output sequencing controller: turns register strobes into a burst
// of quadrature A/B edges at a programmed rate, tracks a wrapping position
// counter and reports busy/done/remaining-edge status back to the registers.
module encout_ctrl #(
    parameter int CW = 16
) (
    input  logic          i_pclk,
    input  logic          i_prst,
    input  logic          i_en,
    input  logic          i_dir,
    input  logic [CW-1:0] i_period,
    input  logic          i_str,
    input  logic [CW-1:0] i_outcnt,
    input  logic [CW-1:0] i_posmax,
    input  logic          i_pos_we,
    input  logic [CW-1:0] i_pos_wdata,
    output logic          o_enc_a,
    output logic          o_enc_b,
    output logic [CW-1:0] o_poscnt,
    output logic [CW-1:0] o_remain,
    output logic          o_busy,
    output logic          o_done
);

    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] div_q, div_d;
    logic [CW-1:0] poscnt_q, poscnt_d;
    logic [CW-1:0] remain_q, remain_d;
    logic [1:0]    phase_q, phase_d;
    logic          enc_a_q, enc_b_q;
    logic          done_q, done_d;

    logic [CW-1:0] peff_m1;
    logic          start;
    logic          abort;
    logic          edge_hit;

    // Position step with wrap modulo POSMAX+1; values already above POSMAX
    // (possible after a direct POSCNT write) wrap to 0 on the next up step.
    function automatic logic [CW-1:0] pos_step(input logic [CW-1:0] pos,
                                               input logic [CW-1:0] pmax,
                                               input logic          down);
        logic [CW-1:0] r;
        if (down) begin
            r = (pos == '0) ? pmax : pos - ONE;
        end else begin
            r = (pos >= pmax) ? '0 : pos + ONE;
        end
        return r;
    endfunction

    // Quadrature phase advances +1 (up) or -1 (down) modulo 4.
    function automatic logic [1:0] phase_step(input logic [1:0] p,
                                              input logic       down);
        return down ? (p - 2'd1) : (p + 2'd1);
    endfunction

    // A is high in phases 1 and 2.
    function automatic logic phase_to_a(input logic [1:0] p);
        return (p == 2'd1) || (p == 2'd2);
    endfunction

    // B is high in phases 2 and 3.
    function automatic logic phase_to_b(input logic [1:0] p);
        return (p == 2'd2) || (p == 2'd3);
    endfunction

    // Effective period minus one; a programmed period of 0 behaves as 1.
    // The divider compare uses >= so that shrinking the live period mid-count
    // fires the edge immediately rather than letting the divider run away.
    always_comb begin
        peff_m1  = (i_period == '0) ? '0 : (i_period - ONE);
        start    = (state_q == IDLE) && i_str && i_en && (i_outcnt != '0);
        abort    = (state_q == RUN) && !i_en;
        edge_hit = (state_q == RUN) && (div_q >= peff_m1);
    end

    // Next-state and datapath update; abort wins over a coincident edge and
    // a POSCNT write wins over a coincident position step.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        phase_d  = phase_q;
        poscnt_d = poscnt_q;
        remain_d = remain_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    div_d    = '0;
                    remain_d = i_outcnt;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (edge_hit) begin
                    div_d    = '0;
                    phase_d  = phase_step(phase_q, i_dir);
                    poscnt_d = pos_step(poscnt_q, i_posmax, i_dir);
                    remain_d = remain_q - ONE;
                    if (remain_q == ONE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    div_d = div_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (i_pos_we) begin
            poscnt_d = i_pos_wdata;
        end
    end

    // State, counters and registered A/B outputs; reset clears everything.
    always_ff @(posedge i_pclk) begin
        if (i_prst) begin
            state_q  <= IDLE;
            div_q    <= '0;
            phase_q  <= 2'd0;
            poscnt_q <= '0;
            remain_q <= '0;
            enc_a_q  <= 1'b0;
            enc_b_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            phase_q  <= phase_d;
            poscnt_q <= poscnt_d;
            remain_q <= remain_d;
            enc_a_q  <= phase_to_a(phase_d);
            enc_b_q  <= phase_to_b(phase_d);
            done_q   <= done_d;
        end
    end

    assign o_enc_a  = enc_a_q;
    assign o_enc_b  = enc_b_q;
    assign o_poscnt = poscnt_q;
    assign o_remain = remain_q;
    assign o_busy   = (state_q == RUN);
    assign o_done   = done_q;

endmodule

// File: tb/tb_encout_ctrl.sv
// Directed bench for encout_ctrl: a per-cycle vector table for the short
// sequences, plus hand-written multi-cycle bursts for the longer corner cases.
module tb_encout_ctrl;

    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          dir;
    logic [CW-1:0] period;
    logic          str;
    logic [CW-1:0] outcnt;
    logic [CW-1:0] posmax;
    logic          pos_we;
    logic [CW-1:0] wdata;
    logic          enc_a;
    logic          enc_b;
    logic [CW-1:0] poscnt;
    logic [CW-1:0] remain;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_errors = 0;

    encout_ctrl #(.CW(CW)) dut (
        .i_pclk      (clk),
        .i_prst      (rst),
        .i_en        (en),
        .i_dir       (dir),
        .i_period    (period),
        .i_str       (str),
        .i_outcnt    (outcnt),
        .i_posmax    (posmax),
        .i_pos_we    (pos_we),
        .i_pos_wdata (wdata),
        .o_enc_a     (enc_a),
        .o_enc_b     (enc_b),
        .o_poscnt    (poscnt),
        .o_remain    (remain),
        .o_busy      (busy),
        .o_done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          en;
        logic          dir;
        logic [CW-1:0] period;
        logic          str;
        logic [CW-1:0] outcnt;
        logic [CW-1:0] posmax;
        logic          we;
        logic [CW-1:0] wdata;
        logic [1:0]    ab;
        logic [CW-1:0] pos;
        logic [CW-1:0] rem;
        logic          busy;
        logic          done;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl [NV];

    function automatic vec_t mkv(input logic r, input logic e, input logic d,
                                 input int per, input logic s, input int oc,
                                 input int pm, input logic w, input int wd,
                                 input logic [1:0] ab, input int pos,
                                 input int rem, input logic bsy, input logic dn);
        vec_t v;
        v.rst = r;      v.en = e;        v.dir = d;
        v.period = per[CW-1:0];          v.str = s;
        v.outcnt = oc[CW-1:0];           v.posmax = pm[CW-1:0];
        v.we = w;       v.wdata = wd[CW-1:0];
        v.ab = ab;      v.pos = pos[CW-1:0];
        v.rem = rem[CW-1:0];
        v.busy = bsy;   v.done = dn;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string nm, input logic [1:0] ab, input int pos,
                           input int rem, input logic bsy, input logic dn);
        chk({nm, "_ab"},     {30'd0, enc_a, enc_b}, {30'd0, ab});
        chk({nm, "_pos"},    {16'd0, poscnt}, pos);
        chk({nm, "_remain"}, {16'd0, remain}, rem);
        chk({nm, "_busy"},   {31'd0, busy}, {31'd0, bsy});
        chk({nm, "_done"},   {31'd0, done}, {31'd0, dn});
    endtask

    logic [1:0] up_seq [4];
    int         edges;
    logic       got_done;

    initial begin
        up_seq[0] = 2'b00; up_seq[1] = 2'b10; up_seq[2] = 2'b11; up_seq[3] = 2'b01;

        //              rst en dir per str oc pm we wd | ab   pos rem busy done
        tbl[0]  = mkv(1, 0, 0, 0, 0, 0, 0, 0, 0,  2'b00, 0, 0, 0, 0);
        // down wrap: POSMAX=9, POSCNT=1, PERIOD=1, OUTCNT=3
        tbl[1]  = mkv(0, 1, 0, 1, 0, 0, 9, 1, 1,  2'b00, 1, 0, 0, 0);
        tbl[2]  = mkv(0, 1, 1, 1, 1, 3, 9, 0, 0,  2'b00, 1, 3, 1, 0);
        tbl[3]  = mkv(0, 1, 1, 1, 0, 3, 9, 0, 0,  2'b01, 0, 2, 1, 0);
        tbl[4]  = mkv(0, 1, 1, 1, 0, 3, 9, 0, 0,  2'b11, 9, 1, 1, 0);
        tbl[5]  = mkv(0, 1, 1, 1, 0, 3, 9, 0, 0,  2'b10, 8, 0, 0, 1);
        tbl[6]  = mkv(0, 1, 1, 1, 0, 3, 9, 0, 0,  2'b10, 8, 0, 0, 0);
        // OUTCNT=0 strobe is ignored
        tbl[7]  = mkv(0, 1, 0, 0, 1, 0, 9, 0, 0,  2'b10, 8, 0, 0, 0);
        tbl[8]  = mkv(0, 1, 0, 0, 0, 0, 9, 0, 0,  2'b10, 8, 0, 0, 0);
        // PERIOD=0, OUTCNT=5: an edge every clock, up wrap 9 -> 0
        tbl[9]  = mkv(0, 1, 0, 0, 1, 5, 9, 0, 0,  2'b10, 8, 5, 1, 0);
        tbl[10] = mkv(0, 1, 0, 0, 0, 5, 9, 0, 0,  2'b11, 9, 4, 1, 0);
        tbl[11] = mkv(0, 1, 0, 0, 0, 5, 9, 0, 0,  2'b01, 0, 3, 1, 0);
        tbl[12] = mkv(0, 1, 0, 0, 0, 5, 9, 0, 0,  2'b00, 1, 2, 1, 0);
        tbl[13] = mkv(0, 1, 0, 0, 0, 5, 9, 0, 0,  2'b10, 2, 1, 1, 0);
        tbl[14] = mkv(0, 1, 0, 0, 0, 5, 9, 0, 0,  2'b11, 3, 0, 0, 1);
        // new strobe accepted while done is high
        tbl[15] = mkv(0, 1, 0, 1, 1, 1, 9, 0, 0,  2'b11, 3, 1, 1, 0);
        tbl[16] = mkv(0, 1, 0, 1, 0, 1, 9, 0, 0,  2'b01, 4, 0, 0, 1);
        tbl[17] = mkv(0, 1, 0, 1, 0, 1, 9, 0, 0,  2'b01, 4, 0, 0, 0);

        rst = 1'b1; en = 1'b0; dir = 1'b0; period = '0; str = 1'b0;
        outcnt = '0; posmax = '0; pos_we = 1'b0; wdata = '0;
        step();
        step();

        for (int i = 0; i < NV; i++) begin
            rst = tbl[i].rst; en = tbl[i].en; dir = tbl[i].dir;
            period = tbl[i].period; str = tbl[i].str; outcnt = tbl[i].outcnt;
            posmax = tbl[i].posmax; pos_we = tbl[i].we; wdata = tbl[i].wdata;
            step();
            chk_all($sformatf("v%0d", i), tbl[i].ab, int'(tbl[i].pos),
                    int'(tbl[i].rem), tbl[i].busy, tbl[i].done);
        end
        str = 1'b0; pos_we = 1'b0;

        // Basic up burst: PERIOD=4, OUTCNT=8 from phase 0, position 0
        rst = 1'b1;
        step();
        chk_all("rst", 2'b00, 0, 0, 1'b0, 1'b0);
        rst = 1'b0; en = 1'b1; dir = 1'b0; period = 16'd4; outcnt = 16'd8;
        posmax = 16'd99; str = 1'b1;
        step();
        str = 1'b0;
        chk_all("up_k0", 2'b00, 0, 8, 1'b1, 1'b0);
        for (int k = 1; k <= 36; k++) begin
            step();
            edges = (k / 4 > 8) ? 8 : k / 4;
            chk($sformatf("up_k%0d_ab", k), {30'd0, enc_a, enc_b}, {30'd0, up_seq[edges % 4]});
            chk($sformatf("up_k%0d_busy", k), {31'd0, busy}, {31'd0, (k < 32)});
            chk($sformatf("up_k%0d_done", k), {31'd0, done}, {31'd0, (k == 32)});
            chk($sformatf("up_k%0d_rem", k), {16'd0, remain}, 8 - edges);
        end
        chk("up_pos", {16'd0, poscnt}, 8);

        // Abort after the 3rd edge: PERIOD=2, OUTCNT=10
        period = 16'd2; outcnt = 16'd10; str = 1'b1;
        step();
        str = 1'b0;
        for (int k = 1; k <= 6; k++) step();
        chk_all("ab_pre", 2'b01, 11, 7, 1'b1, 1'b0);
        en = 1'b0;
        step();
        chk_all("ab_k7", 2'b01, 11, 7, 1'b0, 1'b0);
        step();
        step();
        chk_all("ab_k9", 2'b01, 11, 7, 1'b0, 1'b0);

        // POSCNT write on an edge, second strobe during RUN ignored
        en = 1'b1; period = 16'd2; outcnt = 16'd4; str = 1'b1;
        step();
        chk_all("col_k0", 2'b01, 11, 4, 1'b1, 1'b0);
        outcnt = 16'd9;
        step();
        str = 1'b0; outcnt = 16'd4;
        chk_all("col_k1", 2'b01, 11, 4, 1'b1, 1'b0);
        pos_we = 1'b1; wdata = 16'd50;
        step();
        pos_we = 1'b0;
        chk_all("col_k2", 2'b00, 50, 3, 1'b1, 1'b0);
        got_done = 1'b0;
        for (int k = 0; k < 20 && !got_done; k++) begin
            step();
            if (done) got_done = 1'b1;
        end
        chk("col_done_seen", {31'd0, got_done}, 32'd1);
        chk_all("col_end", 2'b01, 53, 0, 1'b0, 1'b1);

        // Reset mid-burst, then a clean restart from phase 0
        period = 16'd3; outcnt = 16'd6; str = 1'b1;
        step();
        str = 1'b0;
        for (int k = 1; k <= 6; k++) step();
        chk_all("mr_pre", 2'b10, 55, 4, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all("mr_rst", 2'b00, 0, 0, 1'b0, 1'b0);
        period = 16'd1; outcnt = 16'd2; str = 1'b1;
        step();
        str = 1'b0;
        chk_all("mr_k0", 2'b00, 0, 2, 1'b1, 1'b0);
        step();
        chk_all("mr_k1", 2'b10, 1, 1, 1'b1, 1'b0);
        step();
        chk_all("mr_k2", 2'b11, 2, 0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
